// File: rtl/hazard_ctrl_if.sv
// Pipeline control bundle driven by the hazard unit toward IF/ID and the later stage registers.
interface hazard_ctrl_if;
    logic if_id_stall;
    logic if_id_flush;
    logic pc_write;
    logic id_ex_bubble;
    logic pipe_hold;

    modport master (
        output if_id_stall,
        output if_id_flush,
        output pc_write,
        output id_ex_bubble,
        output pipe_hold
    );

    modport slave (
        input if_id_stall,
        input if_id_flush,
        input pc_write,
        input id_ex_bubble,
        input pipe_hold
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stall, taken-branch flush,
// whole-pipe freeze during a data-memory miss, saturating perf counters and a
// sticky miss-timeout flag.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned TO_W  = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             id_branch_i,
    input  logic             id_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    hazard_ctrl_if.master    ctl,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    localparam int unsigned REG_W = 5;

    // The wait counter excludes the request cycle and the current cycle, so a
    // miss times out after 2^TO_W-1 held cycles in total.
    localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - TO_W'(2);

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        MISS_WAIT = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_nxt;
    logic [TO_W-1:0] wait_q;
    logic [TO_W-1:0] wait_nxt;
    logic            timeout_c;
    logic            lu_c;
    logic            hold_c;
    logic            stall_c;
    logic            flush_c;
    logic            pc_write_c;
    logic            bubble_c;
    logic            pipe_hold_c;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    always_comb begin
        lu_c = ex_memread_i && (ex_rd_i != REG_W'(0)) &&
               ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
        hold_c = ((state_q == RUN) && mem_req_i && !mem_ack_i) ||
                 ((state_q == MISS_WAIT) && !mem_ack_i);
    end

    // Next-state, wait counter and prioritised pipeline controls.
    always_comb begin
        state_nxt   = state_q;
        wait_nxt    = wait_q;
        timeout_c   = 1'b0;
        stall_c     = 1'b0;
        flush_c     = 1'b0;
        pc_write_c  = 1'b0;
        bubble_c    = 1'b0;
        pipe_hold_c = 1'b0;

        if (!start_i) begin
            state_nxt = RUN;
            wait_nxt  = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_req_i && !mem_ack_i) begin
                        state_nxt = MISS_WAIT;
                        wait_nxt  = '0;
                    end
                end
                MISS_WAIT: begin
                    if (mem_ack_i) begin
                        state_nxt = RUN;
                        wait_nxt  = '0;
                    end else if (wait_q == TO_LAST) begin
                        state_nxt = RUN;
                        wait_nxt  = '0;
                        timeout_c = 1'b1;
                    end else begin
                        wait_nxt = wait_q + TO_W'(1);
                    end
                end
                default: begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            endcase

            if (hold_c) begin
                pipe_hold_c = 1'b1;
                stall_c     = 1'b1;
            end else if (lu_c) begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
            end else if (id_branch_i && id_taken_i) begin
                flush_c    = 1'b1;
                pc_write_c = 1'b1;
            end else begin
                pc_write_c = 1'b1;
            end
        end
    end

    assign ctl.if_id_stall  = stall_c;
    assign ctl.if_id_flush  = flush_c;
    assign ctl.pc_write     = pc_write_c;
    assign ctl.id_ex_bubble = bubble_c;
    assign ctl.pipe_hold    = pipe_hold_c;

    // FSM state and miss-wait counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_nxt;
            wait_q  <= wait_nxt;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_o <= 1'b0;
        end else if (timeout_c) begin
            err_o <= 1'b1;
        end
    end

    // Saturating stall/flush cycle counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_c && (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (flush_c && (flush_cnt_o != {CNT_W{1'b1}})) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a small expected-value scoreboard.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TO_W  = 3;

    // Control vector order: {stall, flush, pc_write, bubble, hold}
    localparam logic [4:0] C_RUN   = 5'b00100;
    localparam logic [4:0] C_LU    = 5'b10010;
    localparam logic [4:0] C_HOLD  = 5'b10001;
    localparam logic [4:0] C_FLUSH = 5'b01100;
    localparam logic [4:0] C_OFF   = 5'b00000;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_use_rs1_i;
    logic             id_use_rs2_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rd_i;
    logic             id_branch_i;
    logic             id_taken_i;
    logic             mem_req_i;
    logic             mem_ack_i;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             err_o;

    hazard_ctrl_if ctl ();

    hazard_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .ex_memread_i (ex_memread_i),
        .ex_rd_i      (ex_rd_i),
        .id_branch_i  (id_branch_i),
        .id_taken_i   (id_taken_i),
        .mem_req_i    (mem_req_i),
        .mem_ack_i    (mem_ack_i),
        .ctl          (ctl),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string            tag;
        logic [4:0]       ctrl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        logic             err;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] m_sc  = '0;
    logic [CNT_W-1:0] m_fc  = '0;

    task automatic check_pop();
        exp_t       e;
        logic [4:0] obs;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_empty observed=0 entries expected=1 entry");
        end
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctl.if_id_stall, ctl.if_id_flush, ctl.pc_write,
                   ctl.id_ex_bubble, ctl.pipe_hold};
            n_cmp += 4;
            assert (obs === e.ctrl) else begin
                n_err++;
                $error("FAIL %s.ctrl observed=%b expected=%b", e.tag, obs, e.ctrl);
            end
            assert (stall_cnt_o === e.sc) else begin
                n_err++;
                $error("FAIL %s.stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt_o, e.sc);
            end
            assert (flush_cnt_o === e.fc) else begin
                n_err++;
                $error("FAIL %s.flush_cnt observed=%0d expected=%0d", e.tag, flush_cnt_o, e.fc);
            end
            assert (err_o === e.err) else begin
                n_err++;
                $error("FAIL %s.err observed=%b expected=%b", e.tag, err_o, e.err);
            end
        end
    endtask

    // One clock cycle: enqueue expectation, compare at negedge, advance counter model.
    task automatic cyc(input string tag, input logic [4:0] c, input logic e);
        sb.push_back('{tag, c, m_sc, m_fc, e});
        @(negedge clk_i);
        check_pop();
        @(posedge clk_i);
        if (rst_i) begin
            if (c[4] && (m_sc != {CNT_W{1'b1}})) m_sc = m_sc + CNT_W'(1);
            if (c[3] && (m_fc != {CNT_W{1'b1}})) m_fc = m_fc + CNT_W'(1);
        end
        #1;
    endtask

    task automatic idle();
        id_rs1_i     = 5'd0;
        id_rs2_i     = 5'd0;
        id_use_rs1_i = 1'b0;
        id_use_rs2_i = 1'b0;
        ex_memread_i = 1'b0;
        ex_rd_i      = 5'd0;
        id_branch_i  = 1'b0;
        id_taken_i   = 1'b0;
        mem_req_i    = 1'b0;
        mem_ack_i    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b0;
        m_sc  = '0;
        m_fc  = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_i   = 1'b0;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        cyc("reset_idle", C_OFF, 1'b0);
        rst_i   = 1'b1;
        start_i = 1'b1;
        cyc("run_idle", C_RUN, 1'b0);

        // Load-use on rs1, then bubble in EX clears it
        ex_memread_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_use_rs1_i = 1'b1;
        cyc("lu_rs1", C_LU, 1'b0);
        ex_memread_i = 1'b0;
        cyc("lu_after", C_RUN, 1'b0);
        ex_memread_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0;
        cyc("lu_x0", C_RUN, 1'b0);
        ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_use_rs1_i = 1'b0;
        cyc("lu_nouse", C_RUN, 1'b0);

        // Taken branch, then branch waiting on a load via rs2
        idle();
        id_branch_i = 1'b1; id_taken_i = 1'b1;
        cyc("br_taken", C_FLUSH, 1'b0);
        id_taken_i = 1'b0;
        cyc("br_not_taken", C_RUN, 1'b0);
        id_taken_i = 1'b1; ex_memread_i = 1'b1; ex_rd_i = 5'd7;
        id_rs2_i = 5'd7; id_use_rs2_i = 1'b1;
        cyc("br_lu_rs2", C_LU, 1'b0);
        ex_memread_i = 1'b0;
        cyc("br_after_lu", C_FLUSH, 1'b0);
        idle();
        cyc("br_done", C_RUN, 1'b0);

        // Four-cycle miss
        do_reset();
        mem_req_i = 1'b1;
        cyc("miss_c0", C_HOLD, 1'b0);
        mem_req_i = 1'b0;
        for (int i = 1; i < 4; i++) cyc("miss_wait", C_HOLD, 1'b0);
        mem_ack_i = 1'b1;
        cyc("miss_ack", C_RUN, 1'b0);
        mem_ack_i = 1'b0;
        cyc("miss_done", C_RUN, 1'b0);

        // Hit, stray ack in RUN, request during MISS_WAIT
        mem_req_i = 1'b1; mem_ack_i = 1'b1;
        cyc("hit", C_RUN, 1'b0);
        mem_req_i = 1'b0;
        cyc("ack_in_run", C_RUN, 1'b0);
        mem_ack_i = 1'b0; mem_req_i = 1'b1;
        cyc("miss2_c0", C_HOLD, 1'b0);
        cyc("req_in_wait", C_HOLD, 1'b0);
        mem_req_i = 1'b0; mem_ack_i = 1'b1;
        cyc("miss2_ack", C_RUN, 1'b0);
        mem_ack_i = 1'b0;

        // Timeout: seven held cycles, then sticky error in RUN
        do_reset();
        mem_req_i = 1'b1;
        cyc("to_c0", C_HOLD, 1'b0);
        mem_req_i = 1'b0;
        for (int i = 1; i < 7; i++) cyc("to_wait", C_HOLD, 1'b0);
        cyc("to_fired", C_RUN, 1'b1);
        mem_ack_i = 1'b1;
        cyc("to_late_ack", C_RUN, 1'b1);
        mem_ack_i = 1'b0;
        cyc("to_err_sticky", C_RUN, 1'b1);

        // start_i low during a hazard and during MISS_WAIT
        ex_memread_i = 1'b1; ex_rd_i = 5'd3; id_rs1_i = 5'd3; id_use_rs1_i = 1'b1;
        start_i = 1'b0;
        cyc("stop_lu", C_OFF, 1'b1);
        start_i = 1'b1;
        cyc("start_lu", C_LU, 1'b1);
        idle();
        mem_req_i = 1'b1;
        cyc("stop_miss_c0", C_HOLD, 1'b1);
        mem_req_i = 1'b0; start_i = 1'b0;
        cyc("stop_in_wait", C_OFF, 1'b1);
        start_i = 1'b1;
        cyc("forced_run", C_RUN, 1'b1);

        // Asynchronous reset in the middle of a miss
        mem_req_i = 1'b1;
        cyc("rmid_c0", C_HOLD, 1'b1);
        mem_req_i = 1'b0;
        cyc("rmid_wait", C_HOLD, 1'b1);
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        m_sc  = '0;
        m_fc  = '0;
        sb.push_back('{"rst_mid_miss", C_RUN, m_sc, m_fc, 1'b0});
        #1;
        check_pop();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        cyc("rst_then_run", C_RUN, 1'b0);

        // Stall counter saturation
        do_reset();
        ex_memread_i = 1'b1; ex_rd_i = 5'd9; id_rs2_i = 5'd9; id_use_rs2_i = 1'b1;
        for (int i = 0; i < 20; i++) cyc("sat_lu", C_LU, 1'b0);
        idle();
        cyc("sat_final", C_RUN, 1'b0);
        n_cmp++;
        assert (stall_cnt_o === 4'd15) else begin
            n_err++;
            $error("FAIL sat_value observed=%0d expected=15", stall_cnt_o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
